// File: rtl/edge_detector_multi_if.sv
// Bundle of the per-channel pin inputs, shared controls and event outputs
// of edge_detector_multi. The master drives the raw inputs and controls,
// the slave (the detector) drives the filtered level and event flags.
interface edge_detector_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] sig;
  logic [1:0]          mode;
  logic                en;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overflow;
  logic                irq;

  modport master (
    output sig, mode, en, clr,
    input  level, tick, pending, overflow, irq
  );

  modport slave (
    input  sig, mode, en, clr,
    output level, tick, pending, overflow, irq
  );
endinterface

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector for asynchronous pins: per channel a
// synchroniser, a stability filter, a polarity-selectable one-cycle tick,
// sticky pending/overflow flags and an OR-reduced interrupt.
// The filter samples the synchronised value through one extra register, so a
// pin change captured by the first sync flop on edge 0 reaches level/tick on
// edge SYNC_STAGES+FILTER_CYCLES.
module edge_detector_multi #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input logic                  clk,
  input logic                  reset,
  edge_detector_multi_if.slave bus
);

  localparam int CW = $clog2(FILTER_CYCLES) + 1;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] samp_q;
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CW-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic                irq_q, irq_d;
  logic                rise_ok_s, fall_ok_s;

  // Metastability chain: each pin walks through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.sig;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Filter input sample of the synchronised value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= '0;
    end else begin
      samp_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Next-state: stability filter, tick qualification, sticky flags and irq.
  always_comb begin
    rise_ok_s = bus.en & ((bus.mode == 2'b00) | (bus.mode == 2'b10));
    fall_ok_s = bus.en & ((bus.mode == 2'b01) | (bus.mode == 2'b10));
    level_d   = level_q;
    tick_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
        // Mismatch has persisted long enough: accept it as the new level.
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
        tick_d[i]  = level_q[i] ? fall_ok_s : rise_ok_s;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // A new event wins over a simultaneous clear so it is never lost.
    pend_d = tick_d | (pend_q & ~bus.clr);
    ovf_d  = (tick_d & pend_q & ~bus.clr) | (ovf_q & ~bus.clr);
    irq_d  = |pend_d;
  end

  // Filter counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Registered outputs: level, tick, pending, overflow and irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      tick_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.level    = level_q;
  assign bus.tick     = tick_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;
  assign bus.irq      = irq_q;

endmodule
